// File: rtl/shape_cmd_pkg.sv
// Shared definitions for the shape control SFR command sequencer:
// field positions, keep codes, sequencer states and the accept rule.
package shape_cmd_pkg;

    localparam int SHAPE_LSB = 16;
    localparam int SHAPE_W   = 3;
    localparam int OP_LSB    = 0;
    localparam int OP_W      = 7;

    localparam logic [SHAPE_W-1:0] KEEP_SHAPE = 3'b111;
    localparam logic [OP_W-1:0]    KEEP_OP    = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } seq_state_e;

    // A field passes if it carries the keep code or the read-back holds the
    // requested value; the command is accepted only if both fields pass.
    function automatic logic field_match(input logic [31:0] cmd, input logic [31:0] rd);
        logic [SHAPE_W-1:0] cmd_shape;
        logic [SHAPE_W-1:0] rd_shape;
        logic [OP_W-1:0]    cmd_op;
        logic [OP_W-1:0]    rd_op;
        logic               shape_ok;
        logic               op_ok;
        cmd_shape = cmd[SHAPE_LSB +: SHAPE_W];
        rd_shape  = rd[SHAPE_LSB +: SHAPE_W];
        cmd_op    = cmd[OP_LSB +: OP_W];
        rd_op     = rd[OP_LSB +: OP_W];
        shape_ok  = (cmd_shape == KEEP_SHAPE) || (cmd_shape == rd_shape);
        op_ok     = (cmd_op == KEEP_OP) || (cmd_op == rd_op);
        return shape_ok && op_ok;
    endfunction

endpackage

// File: rtl/shape_cmd_fifo.sv
// Synchronous command FIFO with extended pointers (one extra wrap bit) so
// full and empty are distinguishable without a separate counter.
// Read data is combinational from the head entry.
module shape_cmd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Pointer update; pushes are refused while full and pops while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/shape_cmd_sequencer.sv
// Command stage for the shape control SFR: buffers 32-bit write commands,
// replays each as a write strobe followed by a read-back, and reports whether
// the SFR took the requested shape/operation fields.
// Optional statistics counters are built when SHAPE_CMD_STATS_EN is defined.
module shape_cmd_sequencer
    import shape_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_accepted,
    output logic [31:0] rsp_data,
    output logic        sfr_write,
    output logic [31:0] sfr_write_data,
    output logic        sfr_read,
    input  logic [31:0] sfr_read_data,
    output logic        busy
`ifdef SHAPE_CMD_STATS_EN
    ,
    input  logic        stat_clr,
    output logic [15:0] stat_acc_cnt,
    output logic [15:0] stat_rej_cnt
`endif
);

    seq_state_e  state;
    seq_state_e  next_state;
    logic [31:0] cmd_q;
    logic [31:0] rd_q;
    logic [31:0] fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && !fifo_full;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign busy      = (state != IDLE) || !fifo_empty;

    shape_cmd_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (cmd_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sequencer state register; reset drops any in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture the popped command and the SFR read-back for the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= '0;
            rd_q  <= '0;
        end else begin
            if (fifo_pop) begin
                cmd_q <= fifo_rdata;
            end
            if (state == READ) begin
                rd_q <= sfr_read_data;
            end
        end
    end

    // Next-state: one write, one read, then hold the response until taken.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!fifo_empty) next_state = WRITE;
            WRITE:   next_state = READ;
            READ:    next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded purely from state so strobes vanish as soon as reset hits.
    always_comb begin
        sfr_write      = 1'b0;
        sfr_write_data = '0;
        sfr_read       = 1'b0;
        rsp_valid      = 1'b0;
        rsp_accepted   = 1'b0;
        rsp_data       = '0;
        case (state)
            WRITE: begin
                sfr_write      = 1'b1;
                sfr_write_data = cmd_q;
            end
            READ: begin
                sfr_read = 1'b1;
            end
            RESP: begin
                rsp_valid    = 1'b1;
                rsp_accepted = field_match(cmd_q, rd_q);
                rsp_data     = rd_q;
            end
            default: begin
            end
        endcase
    end

`ifdef SHAPE_CMD_STATS_EN
    logic rsp_hs;
    assign rsp_hs = rsp_valid && rsp_ready;

    // Saturating accept/reject counters; a clear overrides a same-cycle count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_acc_cnt <= '0;
            stat_rej_cnt <= '0;
        end else if (stat_clr) begin
            stat_acc_cnt <= '0;
            stat_rej_cnt <= '0;
        end else if (rsp_hs) begin
            if (rsp_accepted) begin
                if (stat_acc_cnt != 16'hFFFF) begin
                    stat_acc_cnt <= stat_acc_cnt + 16'd1;
                end
            end else begin
                if (stat_rej_cnt != 16'hFFFF) begin
                    stat_rej_cnt <= stat_rej_cnt + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_shape_cmd_sequencer.sv
// Self-checking bench for shape_cmd_sequencer. A behavioural SFR model sits on
// the strobe interface; expected responses are predicted when commands are
// pushed and compared when the sequencer presents them.
// Define SHAPE_CMD_STATS_EN to also exercise the statistics counters.
`timescale 1ns/1ps
module tb_shape_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_accepted;
    logic [31:0] rsp_data;
    logic        sfr_write;
    logic [31:0] sfr_write_data;
    logic        sfr_read;
    logic [31:0] sfr_read_data;
    logic        busy;
`ifdef SHAPE_CMD_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_acc_cnt;
    logic [15:0] stat_rej_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic        acc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] sfr_reg;
    logic [31:0] model_sfr;

    always #5 clk = ~clk;

    shape_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_data       (cmd_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_accepted   (rsp_accepted),
        .rsp_data       (rsp_data),
        .sfr_write      (sfr_write),
        .sfr_write_data (sfr_write_data),
        .sfr_read       (sfr_read),
        .sfr_read_data  (sfr_read_data),
        .busy           (busy)
`ifdef SHAPE_CMD_STATS_EN
        ,
        .stat_clr       (stat_clr),
        .stat_acc_cnt   (stat_acc_cnt),
        .stat_rej_cnt   (stat_rej_cnt)
`endif
    );

    // SFR legality: shapes 100..110 are not supported, so such writes are ignored whole.
    function automatic logic shape_legal(input logic [2:0] s);
        return !((s == 3'b100) || (s == 3'b101) || (s == 3'b110));
    endfunction

    // SFR write behaviour: keep codes retain the old field; an illegal result leaves the SFR untouched.
    function automatic logic [31:0] sfr_apply(input logic [31:0] cur, input logic [31:0] wr);
        logic [2:0] sh;
        logic [6:0] op;
        sh = (wr[18:16] == 3'b111) ? cur[18:16] : wr[18:16];
        op = (wr[6:0] == 7'h7F) ? cur[6:0] : wr[6:0];
        if (!shape_legal(sh)) return cur;
        return {13'd0, sh, 9'd0, op};
    endfunction

    assign sfr_read_data = sfr_reg;

    // Behavioural SFR register, deliberately not tied to the sequencer reset.
    always @(posedge clk) begin
        if (sfr_write) sfr_reg <= sfr_apply(sfr_reg, sfr_write_data);
    end

    // Predict the response for a command about to be pushed and advance the SFR model.
    task automatic predict(input logic [31:0] cmd);
        exp_t        e;
        logic [31:0] nxt;
        logic [2:0]  eff_shape;
        nxt       = sfr_apply(model_sfr, cmd);
        eff_shape = (cmd[18:16] == 3'b111) ? model_sfr[18:16] : cmd[18:16];
        if (shape_legal(eff_shape)) begin
            e.acc = 1'b1;
        end else begin
            e.acc = ((cmd[18:16] == 3'b111) || (cmd[18:16] == model_sfr[18:16])) &&
                    ((cmd[6:0] == 7'h7F) || (cmd[6:0] == model_sfr[6:0]));
        end
        e.data    = nxt;
        model_sfr = nxt;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        rsp_ready = 1'b1;
`ifdef SHAPE_CMD_STATS_EN
        stat_clr  = 1'b0;
`endif
        #1;
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_cmd_ready got %b want 1", cmd_ready);
        end
        tests_run++;
        if ({rsp_valid, rsp_accepted, sfr_write, sfr_read, busy} !== 5'b00000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags got %b want 00000",
                     {rsp_valid, rsp_accepted, sfr_write, sfr_read, busy});
        end
        tests_run++;
        if ((rsp_data !== 32'h0) || (sfr_write_data !== 32'h0)) begin
            tests_failed++;
            $display("[TB] FAIL reset_data got rsp=%h wr=%h want 0/0", rsp_data, sfr_write_data);
        end
`ifdef SHAPE_CMD_STATS_EN
        tests_run++;
        if ((stat_acc_cnt !== 16'h0) || (stat_rej_cnt !== 16'h0)) begin
            tests_failed++;
            $display("[TB] FAIL reset_stats got acc=%0d rej=%0d want 0/0", stat_acc_cnt, stat_rej_cnt);
        end
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Single commands with exact cycle-by-cycle latency checks.
    task automatic test_single_cmds();
        logic [31:0] cmds [5];
        exp_t        e;
        cmds[0] = 32'h0001_0001;
        cmds[1] = 32'h0004_0040;
        cmds[2] = 32'h0007_007F;
        cmds[3] = 32'hFFF2_FF13;
        cmds[4] = 32'h0005_007F;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_data  = cmds[i];
            predict(cmds[i]);
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_data  = '0;
            tests_run++;
            if ({sfr_write, sfr_read, rsp_valid, busy} !== 4'b0001) begin
                tests_failed++;
                $display("[TB] FAIL single_n1[%0d] got wr/rd/rv/busy=%b want 0001", i,
                         {sfr_write, sfr_read, rsp_valid, busy});
            end
            @(negedge clk);
            tests_run++;
            if ((sfr_write !== 1'b1) || (sfr_read !== 1'b0) || (sfr_write_data !== cmds[i])) begin
                tests_failed++;
                $display("[TB] FAIL single_write[%0d] got wr=%b rd=%b data=%h want 1/0/%h", i,
                         sfr_write, sfr_read, sfr_write_data, cmds[i]);
            end
            @(negedge clk);
            tests_run++;
            if ((sfr_read !== 1'b1) || (sfr_write !== 1'b0) || (sfr_write_data !== 32'h0)) begin
                tests_failed++;
                $display("[TB] FAIL single_read[%0d] got rd=%b wr=%b data=%h want 1/0/0", i,
                         sfr_read, sfr_write, sfr_write_data);
            end
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if ((rsp_valid !== 1'b1) || (rsp_accepted !== e.acc) || (rsp_data !== e.data)) begin
                tests_failed++;
                $display("[TB] FAIL single_rsp[%0d] got v=%b acc=%b data=%h want 1/%b/%h", i,
                         rsp_valid, rsp_accepted, rsp_data, e.acc, e.data);
            end
            @(negedge clk);
            tests_run++;
            if ((rsp_valid !== 1'b0) || (busy !== 1'b0)) begin
                tests_failed++;
                $display("[TB] FAIL single_done[%0d] got v=%b busy=%b want 0/0", i, rsp_valid, busy);
            end
        end
    endtask

    // Stall responses, fill the buffer, then drain and confirm order and count.
    task automatic test_backpressure();
        logic [31:0] bp [6];
        exp_t        e;
        int          pushed;
        int          got;
        int          quiet_bad;
        bp[0] = 32'h0003_0010;
        bp[1] = 32'h0001_0022;
        bp[2] = 32'h0006_0033;
        bp[3] = 32'h0007_0044;
        bp[4] = 32'h0000_007F;
        bp[5] = 32'h0002_0055;
        pushed = 0;
        got    = 0;
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cmd_ready && (pushed < 6)) begin
                cmd_valid = 1'b1;
                cmd_data  = bp[pushed];
                predict(bp[pushed]);
                pushed++;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        tests_run++;
        if ((pushed != 5) || (cmd_ready !== 1'b0) || (rsp_valid !== 1'b1) || (busy !== 1'b1)) begin
            tests_failed++;
            $display("[TB] FAIL bp_full got pushed=%0d ready=%b rv=%b busy=%b want 5/0/1/1",
                     pushed, cmd_ready, rsp_valid, busy);
        end
        rsp_ready = 1'b1;
        for (int cyc = 0; (cyc < 80) && (got < 6); cyc++) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL bp_extra got unexpected rsp data=%h want none", rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    tests_run++;
                    if ((rsp_accepted !== e.acc) || (rsp_data !== e.data)) begin
                        tests_failed++;
                        $display("[TB] FAIL bp_rsp[%0d] got acc=%b data=%h want %b/%h", got,
                                 rsp_accepted, rsp_data, e.acc, e.data);
                    end
                end
                got++;
            end
            if (cmd_ready && (pushed < 6)) begin
                cmd_valid = 1'b1;
                cmd_data  = bp[pushed];
                predict(bp[pushed]);
                pushed++;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        tests_run++;
        if (got != 6) begin
            tests_failed++;
            $display("[TB] FAIL bp_count got %0d responses want 6", got);
        end
        quiet_bad = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (rsp_valid || busy) quiet_bad++;
            @(negedge clk);
        end
        tests_run++;
        if (quiet_bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL bp_quiet got %0d active cycles want 0", quiet_bad);
        end
    endtask

    // Reset during READ: strobes drop at once and queued commands vanish.
    task automatic test_reset_mid();
        logic [31:0] mid [3];
        logic [31:0] saved;
        exp_t        e;
        int          seen;
        int          noise;
        mid[0] = 32'h0003_0011;
        mid[1] = 32'h0002_0022;
        mid[2] = 32'h0001_0033;
        saved  = model_sfr;
        seen   = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = mid[i];
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        for (int cyc = 0; (cyc < 10) && (sfr_read !== 1'b1); cyc++) @(negedge clk);
        tests_run++;
        if (sfr_read !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mid_reach_read got rd=%b want 1", sfr_read);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({sfr_write, sfr_read, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset got wr/rd/rv/busy/rdy=%b want 00001",
                     {sfr_write, sfr_read, rsp_valid, busy, cmd_ready});
        end
        model_sfr = sfr_apply(saved, mid[0]);
        @(negedge clk);
        rst_n = 1'b1;
        noise = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (rsp_valid || sfr_write || sfr_read) noise++;
        end
        tests_run++;
        if (noise != 0) begin
            tests_failed++;
            $display("[TB] FAIL mid_dropped got %0d active cycles want 0", noise);
        end
        cmd_valid = 1'b1;
        cmd_data  = 32'h0007_0066;
        predict(32'h0007_0066);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int cyc = 0; (cyc < 20) && (seen == 0); cyc++) begin
            if (rsp_valid) seen = 1;
            else @(negedge clk);
        end
        e = exp_q.pop_front();
        tests_run++;
        if ((seen != 1) || (rsp_accepted !== e.acc) || (rsp_data !== e.data)) begin
            tests_failed++;
            $display("[TB] FAIL mid_recover got seen=%0d acc=%b data=%h want 1/%b/%h",
                     seen, rsp_accepted, rsp_data, e.acc, e.data);
        end
        @(negedge clk);
    endtask

`ifdef SHAPE_CMD_STATS_EN
    // Counters track accept/reject handshakes; a clear beats a same-cycle handshake.
    task automatic test_stats();
        logic [31:0] sc [5];
        exp_t        e;
        int          exp_acc;
        int          exp_rej;
        int          seen;
        sc[0] = 32'h0001_0001;
        sc[1] = 32'h0004_0001;
        sc[2] = 32'h0002_0002;
        sc[3] = 32'h0005_0003;
        sc[4] = 32'h0007_0010;
        exp_acc = 0;
        exp_rej = 0;
        rsp_ready = 1'b1;
        stat_clr  = 1'b1;
        @(negedge clk);
        stat_clr  = 1'b0;
        tests_run++;
        if ((stat_acc_cnt !== 16'h0) || (stat_rej_cnt !== 16'h0)) begin
            tests_failed++;
            $display("[TB] FAIL stats_clr got acc=%0d rej=%0d want 0/0", stat_acc_cnt, stat_rej_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = sc[i];
            predict(sc[i]);
            @(negedge clk);
            cmd_valid = 1'b0;
            seen = 0;
            for (int cyc = 0; (cyc < 20) && (seen == 0); cyc++) begin
                if (rsp_valid) seen = 1;
                else @(negedge clk);
            end
            e = exp_q.pop_front();
            if (e.acc) exp_acc++;
            else exp_rej++;
            tests_run++;
            if ((seen != 1) || (rsp_accepted !== e.acc) || (rsp_data !== e.data)) begin
                tests_failed++;
                $display("[TB] FAIL stats_rsp[%0d] got seen=%0d acc=%b data=%h want 1/%b/%h", i,
                         seen, rsp_accepted, rsp_data, e.acc, e.data);
            end
            @(negedge clk);
        end
        tests_run++;
        if ((exp_acc != 3) || (stat_acc_cnt !== 16'(exp_acc)) || (stat_rej_cnt !== 16'(exp_rej))) begin
            tests_failed++;
            $display("[TB] FAIL stats_count got acc=%0d rej=%0d want %0d/%0d (3/2)",
                     stat_acc_cnt, stat_rej_cnt, exp_acc, exp_rej);
        end
        cmd_valid = 1'b1;
        cmd_data  = 32'h0003_0003;
        predict(32'h0003_0003);
        @(negedge clk);
        cmd_valid = 1'b0;
        seen = 0;
        for (int cyc = 0; (cyc < 20) && (seen == 0); cyc++) begin
            if (rsp_valid) seen = 1;
            else @(negedge clk);
        end
        e = exp_q.pop_front();
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        tests_run++;
        if ((seen != 1) || (stat_acc_cnt !== 16'h0) || (stat_rej_cnt !== 16'h0) || (rsp_valid !== 1'b0)) begin
            tests_failed++;
            $display("[TB] FAIL stats_clr_wins got seen=%0d acc=%0d rej=%0d rv=%b want 1/0/0/0",
                     seen, stat_acc_cnt, stat_rej_cnt, rsp_valid);
        end
    endtask
`endif

    initial begin
        sfr_reg   = 32'h0001_0000;
        model_sfr = 32'h0001_0000;
        test_reset();
        test_single_cmds();
        test_backpressure();
        test_reset_mid();
`ifdef SHAPE_CMD_STATS_EN
        test_stats();
`endif
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_left got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
